mul_div_unit: RTL and testbench

Parametrised integer multiply/divide execution unit for the out-of-order core: RV32M/RV64M semantics at any even XLEN, using an in-house pipelined multiplier and an iterative radix-2 divider. It sits between the mul/div reservation station and the CDB arbiter. Requests carry a tag, so multiplies may complete ahead of an older divide. The unit supports flush and valid/ready backpressure on both sides.

---
 rtl/mul_div_if.sv | 26 ++
 rtl/mul_div_unit.sv | 140 ++++++++++++++
 tb/tb_mul_div_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// mul_div_if: request/response handshake bundle between the reservation station, the mul/div unit and the CDB arbiter
interface mul_div_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [TAG_W-1:0] resp_tag;
    logic [XLEN-1:0]  resp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_tag, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_tag, resp_result
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: tagged RV-M multiply pipeline plus iterative restoring divider with flush and backpressure
module mul_div_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 6
) (
    input logic     clk,
    input logic     rst_n,
    input logic     flush,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [XLEN-1:0]        dq, dr, dd, dres;
    logic                   neg_q, neg_r, is_rem;
    logic [TAG_W-1:0]       dtag;
    logic [MUL_STAGES-1:0]  mv;
    logic [TAG_W-1:0]       mt [MUL_STAGES];
    logic [XLEN-1:0]        md [MUL_STAGES];

    logic                   div_done, mul_last, mul_adv, req_fire, mul_acc, div_acc, div_pop;
    logic                   sa, sb, d_signed, a_neg, b_neg, b_zero, ovf, ge;
    logic [2*XLEN-1:0]      prod;
    logic [XLEN-1:0]        mres, abs_a, abs_b, q_nx, r_nx, q_fix, r_fix;
    logic [XLEN:0]          rr, rs;

    assign div_done = state == DONE;
    assign mul_last = mv[MUL_STAGES-1];
    // The whole pipe stalls only when its last stage holds a result that is not leaving this cycle.
    assign mul_adv  = !mul_last || (bus.resp_ready && !div_done && !flush);
    assign bus.req_ready = !flush && (bus.req_op[2] ? state == IDLE : mul_adv);
    assign req_fire = bus.req_valid && bus.req_ready;
    assign mul_acc  = req_fire && !bus.req_op[2];
    assign div_acc  = req_fire && bus.req_op[2];
    assign div_pop  = div_done && bus.resp_ready && !flush;

    // Divider DONE outranks the multiply pipe; outputs read zero when nothing is presented.
    assign bus.resp_valid  = div_done || mul_last;
    assign bus.resp_tag    = div_done ? dtag : mul_last ? mt[MUL_STAGES-1] : '0;
    assign bus.resp_result = div_done ? dres : mul_last ? md[MUL_STAGES-1] : '0;

    // Operands are sign- or zero-extended to 2*XLEN so a single unsigned multiply covers all four ops.
    assign sa   = !(bus.req_op[1] && bus.req_op[0]);
    assign sb   = !bus.req_op[1];
    assign prod = {{XLEN{sa && bus.req_a[XLEN-1]}}, bus.req_a} * {{XLEN{sb && bus.req_b[XLEN-1]}}, bus.req_b};
    assign mres = bus.req_op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign d_signed = !bus.req_op[0];
    assign a_neg    = d_signed && bus.req_a[XLEN-1];
    assign b_neg    = d_signed && bus.req_b[XLEN-1];
    assign abs_a    = a_neg ? -bus.req_a : bus.req_a;
    assign abs_b    = b_neg ? -bus.req_b : bus.req_b;
    assign b_zero   = bus.req_b == '0;
    assign ovf      = d_signed && bus.req_a == {1'b1, {(XLEN-1){1'b0}}} && bus.req_b == '1;

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    assign rr    = {dr, dq[XLEN-1]};
    assign rs    = rr - {1'b0, dd};
    assign ge    = !rs[XLEN];
    assign r_nx  = ge ? rs[XLEN-1:0] : rr[XLEN-1:0];
    assign q_nx  = {dq[XLEN-2:0], ge};
    assign q_fix = neg_q ? -q_nx : q_nx;
    assign r_fix = neg_r ? -r_nx : r_nx;

    // Multiply pipe: valid/tag/result shift together, frozen as a whole when the output is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mt[i] <= '0;
                md[i] <= '0;
            end
        end else if (flush) begin
            mv <= '0;
        end else if (mul_adv) begin
            for (int i = MUL_STAGES - 1; i > 0; i--) begin
                mv[i] <= mv[i-1];
                mt[i] <= mt[i-1];
                md[i] <= md[i-1];
            end
            mv[0] <= mul_acc;
            mt[0] <= bus.req_tag;
            md[0] <= mres;
        end
    end

    // Divider FSM: special cases finish at once, otherwise XLEN restoring steps with sign fix-up on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            dq     <= '0;
            dr     <= '0;
            dd     <= '0;
            dres   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
            dtag   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (div_acc) begin
                    dtag   <= bus.req_tag;
                    is_rem <= bus.req_op[1];
                    cnt    <= '0;
                    if (b_zero || ovf) begin
                        dres  <= bus.req_op[1] ? (b_zero ? bus.req_a : '0) : (b_zero ? '1 : bus.req_a);
                        state <= DONE;
                    end else begin
                        dq    <= abs_a;
                        dr    <= '0;
                        dd    <= abs_b;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        state <= CALC;
                    end
                end
                CALC: begin
                    dq  <= q_nx;
                    dr  <= r_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        dres  <= is_rem ? r_fix : q_fix;
                        state <= DONE;
                    end
                end
                DONE: if (div_pop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of multiply/divide results, latency, ordering, backpressure, flush and reset
module tb_mul_div_unit;
    localparam int XLEN = 32;
    localparam int S    = 3;
    localparam int TW   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    mul_div_if #(.XLEN(XLEN), .TAG_W(TW)) bus ();

    mul_div_unit #(.XLEN(XLEN), .MUL_STAGES(S), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag, input string name);
        drive(op, a, b, tag);
        #1;
        chk({name, " req_ready"}, 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_resp(input int lat, input logic [5:0] tag, input logic [31:0] res, input string name);
        repeat (lat - 1) begin
            chk({name, " early valid"}, 64'(bus.resp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        chk({name, " valid"}, 64'(bus.resp_valid), 64'd1);
        chk({name, " tag"}, 64'(bus.resp_tag), 64'(tag));
        chk({name, " result"}, 64'(bus.resp_result), 64'(res));
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  mop [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] ma  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] mb  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] mr  [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [2:0]  dop [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] da  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] db  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] dr  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [2:0]  sop [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] sa  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] sbv [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] sr  [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [5:0]  got_tag [4];
    logic [31:0] got_res [4];
    int          n;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;

        #2;
        chk("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset resp_tag", 64'(bus.resp_tag), 64'd0);
        chk("reset resp_result", 64'(bus.resp_result), 64'd0);
        chk("reset req_ready mul", 64'(bus.req_ready), 64'd1);
        bus.req_op = 3'd4;
        #1;
        chk("reset req_ready div", 64'(bus.req_ready), 64'd1);
        bus.req_op = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            issue(mop[i], ma[i], mb[i], 6'(i + 1), "mul single");
            expect_resp(3, 6'(i + 1), mr[i], "mul single");
        end
        chk("mul idle after pop", 64'(bus.resp_valid), 64'd0);

        for (int c = 0; c < 7; c++) begin
            if (c >= 3) begin
                chk("b2b valid", 64'(bus.resp_valid), 64'd1);
                chk("b2b tag", 64'(bus.resp_tag), 64'(c + 5));
                chk("b2b result", 64'(bus.resp_result), 64'(mr[c-3]));
            end else begin
                chk("b2b early valid", 64'(bus.resp_valid), 64'd0);
            end
            if (c < 4) begin
                drive(mop[c], ma[c], mb[c], 6'(c + 8));
                #1;
                chk("b2b req_ready", 64'(bus.req_ready), 64'd1);
            end else begin
                bus.req_valid = 1'b0;
                #1;
            end
            @(posedge clk);
            #1;
        end
        chk("b2b drained", 64'(bus.resp_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            issue(dop[i], da[i], db[i], 6'(i + 16), "div normal");
            bus.req_op = 3'd4;
            #1;
            chk("div busy req_ready", 64'(bus.req_ready), 64'd0);
            bus.req_op = 3'd0;
            #1;
            chk("mul ready during calc", 64'(bus.req_ready), 64'd1);
            expect_resp(33, 6'(i + 16), dr[i], "div normal");
        end

        for (int i = 0; i < 4; i++) begin
            issue(sop[i], sa[i], sbv[i], 6'(i + 24), "div special");
            expect_resp(1, 6'(i + 24), sr[i], "div special");
        end

        issue(3'd5, 32'd20, 32'd3, 6'd1, "order div");
        issue(3'd0, 32'd2, 32'd5, 6'd2, "order mul");
        issue(3'd0, 32'd3, 32'd5, 6'd3, "order mul");
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.resp_valid) begin
                if (n < 4) begin
                    got_tag[n] = bus.resp_tag;
                    got_res[n] = bus.resp_result;
                end
                n++;
            end
            @(posedge clk);
            #1;
        end
        chk("order count", 64'(n), 64'd3);
        chk("order tag0", 64'(got_tag[0]), 64'd2);
        chk("order res0", 64'(got_res[0]), 64'd10);
        chk("order tag1", 64'(got_tag[1]), 64'd3);
        chk("order res1", 64'(got_res[1]), 64'd15);
        chk("order tag2", 64'(got_tag[2]), 64'd1);
        chk("order res2", 64'(got_res[2]), 64'd6);

        issue(3'd4, 32'd100, 32'd7, 6'd5, "collide div");
        repeat (29) begin
            @(posedge clk);
            #1;
        end
        issue(3'd0, 32'd6, 32'd7, 6'd6, "collide mul");
        @(posedge clk);
        #1;
        chk("collide none yet", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("collide first valid", 64'(bus.resp_valid), 64'd1);
        chk("collide first tag", 64'(bus.resp_tag), 64'd5);
        chk("collide first result", 64'(bus.resp_result), 64'd14);
        @(posedge clk);
        #1;
        chk("collide second tag", 64'(bus.resp_tag), 64'd6);
        chk("collide second result", 64'(bus.resp_result), 64'd42);
        @(posedge clk);
        #1;
        chk("collide drained", 64'(bus.resp_valid), 64'd0);

        bus.resp_ready = 1'b0;
        issue(3'd0, 32'd2, 32'd3, 6'd10, "bp mul");
        issue(3'd0, 32'd4, 32'd5, 6'd11, "bp mul");
        issue(3'd0, 32'd7, 32'd8, 6'd12, "bp mul");
        bus.req_op = 3'd0;
        #1;
        chk("bp req_ready low", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("bp hold valid", 64'(bus.resp_valid), 64'd1);
            chk("bp hold tag", 64'(bus.resp_tag), 64'd10);
            chk("bp hold result", 64'(bus.resp_result), 64'd6);
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        chk("bp drain tag0", 64'(bus.resp_tag), 64'd10);
        @(posedge clk);
        #1;
        chk("bp drain tag1", 64'(bus.resp_tag), 64'd11);
        chk("bp drain res1", 64'(bus.resp_result), 64'd20);
        @(posedge clk);
        #1;
        chk("bp drain tag2", 64'(bus.resp_tag), 64'd12);
        chk("bp drain res2", 64'(bus.resp_result), 64'd56);
        @(posedge clk);
        #1;
        chk("bp drained", 64'(bus.resp_valid), 64'd0);

        for (int pass = 0; pass < 2; pass++) begin
            issue(3'd7, 32'd100, 32'd7, 6'd20, "kill div");
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            issue(3'd0, 32'd9, 32'd9, 6'd21, "kill mul");
            issue(3'd0, 32'd5, 32'd5, 6'd22, "kill mul");
            if (pass == 0) begin
                flush = 1'b1;
                drive(3'd0, 32'd1, 32'd1, 6'd30);
                #1;
                chk("flush req_ready low", 64'(bus.req_ready), 64'd0);
                @(posedge clk);
                #1;
                flush = 1'b0;
                bus.req_valid = 1'b0;
            end else begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("async reset resp_valid", 64'(bus.resp_valid), 64'd0);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            chk("kill resp_valid", 64'(bus.resp_valid), 64'd0);
            bus.req_op = 3'd4;
            #1;
            chk("kill div idle ready", 64'(bus.req_ready), 64'd1);
            bus.req_op = 3'd0;
            #1;
            chk("kill mul ready", 64'(bus.req_ready), 64'd1);
            issue(3'd0, 32'd2, 32'd3, 6'd23, "kill fresh mul");
            expect_resp(3, 6'd23, 32'd6, "kill fresh mul");
            n = 0;
            for (int c = 0; c < 40; c++) begin
                if (bus.resp_valid) n++;
                @(posedge clk);
                #1;
            end
            chk("kill no stale results", 64'(n), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
